// File: rtl/fpu_pkg.sv
// Shared FPU datapath definitions: mantissa/quotient widths, divider FSM
// state encoding and the fixed divider latency.
package fpu_pkg;

    localparam int MW          = 24;
    localparam int QW          = MW + 2;
    localparam int CW          = $clog2(QW);
    localparam int DIV_LATENCY = QW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step (combinational).
// Ports: i_rem (partial remainder, MW+1 bits), i_divisor (MW bits),
//        o_rem_next (remainder after conditional subtract, shifted left),
//        o_q_bit (quotient bit of this step).
module div_step
    import fpu_pkg::*;
#(
    parameter int W = MW
) (
    input  logic [W:0]   i_rem,
    input  logic [W-1:0] i_divisor,
    output logic [W:0]   o_rem_next,
    output logic         o_q_bit
);

    logic [W:0] w_div_ext;
    logic [W:0] w_diff;

    assign w_div_ext = {1'b0, i_divisor};
    assign o_q_bit   = (i_rem >= w_div_ext);
    assign w_diff    = o_q_bit ? (i_rem - w_div_ext) : i_rem;
    // The post-subtract remainder is below the divisor, so its top bit is
    // always clear and the shift never loses information.
    assign o_rem_next = w_diff << 1;

endmodule

// File: rtl/mant_div_seq.sv
// Sequential radix-2 restoring mantissa divider, one quotient bit per clock.
// Ports: i_clk, i_reset (sync, active-high), i_start, i_dividend, i_divisor,
//        o_ready, o_done (1-cycle pulse), o_quotient (MW+2 bits incl. guard
//        and round), o_sticky (remainder nonzero), o_div_by_zero.
// Option: define DIV_EARLY_TERM_EN to finish as soon as the remainder is 0.
module mant_div_seq
    import fpu_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [MW-1:0] i_dividend,
    input  logic [MW-1:0] i_divisor,
    output logic          o_ready,
    output logic          o_done,
    output logic [QW-1:0] o_quotient,
    output logic          o_sticky,
    output logic          o_div_by_zero
);

    div_state_e    r_state;
    div_state_e    w_state_next;
    logic [MW:0]   r_rem;
    logic [MW-1:0] r_divisor;
    logic [QW-1:0] r_quot;
    logic [CW-1:0] r_cnt;
    logic          r_sticky;
    logic          r_dbz;

    logic [MW:0]   w_rem_next;
    logic          w_q_bit;
    logic          w_accept;
    logic          w_div_zero;
    logic          w_last;

    div_step #(.W(MW)) u_step (
        .i_rem      (r_rem),
        .i_divisor  (r_divisor),
        .o_rem_next (w_rem_next),
        .o_q_bit    (w_q_bit)
    );

    assign w_accept   = i_start && (r_state != S_RUN);
    assign w_div_zero = (i_divisor == '0);

`ifdef DIV_EARLY_TERM_EN
    // A zero remainder means every remaining quotient bit is zero.
    assign w_last = (r_cnt == '0) || (w_rem_next == '0);
`else
    assign w_last = (r_cnt == '0);
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_div_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_state_next = w_div_zero ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rem     <= '0;
            r_divisor <= '0;
            r_quot    <= '0;
            r_cnt     <= '0;
            r_sticky  <= 1'b0;
            r_dbz     <= 1'b0;
        end else if (w_accept) begin
            r_rem     <= {1'b0, i_dividend};
            r_divisor <= i_divisor;
            r_cnt     <= CW'(QW - 1);
            r_sticky  <= 1'b0;
            r_dbz     <= w_div_zero;
            r_quot    <= w_div_zero ? '1 : '0;
        end else if (r_state == S_RUN) begin
            r_quot[r_cnt] <= w_q_bit;
            r_rem         <= w_rem_next;
            r_cnt         <= r_cnt - 1'b1;
            if (w_last) begin
                r_sticky <= (w_rem_next != '0);
            end
        end
    end

    assign o_ready       = (r_state != S_RUN);
    assign o_done        = (r_state == S_DONE);
    assign o_quotient    = r_quot;
    assign o_sticky      = r_sticky;
    assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_mant_div_seq.sv
// Randomized self-checking bench for mant_div_seq against an arithmetic
// model of the quotient, sticky bit and completion cycle.
module tb_mant_div_seq;

    localparam int MW = 24;
    localparam int QW = 26;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_start = 1'b0;
    logic [MW-1:0] i_dividend = '0;
    logic [MW-1:0] i_divisor = '0;
    logic          o_ready;
    logic          o_done;
    logic [QW-1:0] o_quotient;
    logic          o_sticky;
    logic          o_div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int            start;
        int            done;
        logic [QW-1:0] q;
        logic          s;
        logic          z;
    } exp_t;

    exp_t exp_q[$];
    logic [QW-1:0] hold_q = '0;
    logic          hold_s = 1'b0;
    logic          hold_z = 1'b0;
    logic          checking = 1'b0;

    mant_div_seq dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_ready       (o_ready),
        .o_done        (o_done),
        .o_quotient    (o_quotient),
        .o_sticky      (o_sticky),
        .o_div_by_zero (o_div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h required %h",
                     name, cyc, act, req);
        end
    endtask

    function automatic logic [QW-1:0] m_quot(input logic [MW-1:0] a,
                                             input logic [MW-1:0] b);
        longint unsigned num;
        if (b == 0) return '1;
        num = longint'(a) << (QW - 1);
        return QW'(num / longint'(b));
    endfunction

    function automatic logic m_sticky(input logic [MW-1:0] a,
                                      input logic [MW-1:0] b);
        longint unsigned num;
        if (b == 0) return 1'b0;
        num = longint'(a) << (QW - 1);
        return (num % longint'(b)) != 0;
    endfunction

    // Cycles from the Start edge to the edge that samples Done high.
    function automatic int m_lat(input logic [MW-1:0] a,
                                 input logic [MW-1:0] b);
        if (b == 0) return 1;
`ifdef DIV_EARLY_TERM_EN
        for (int k = 1; k <= QW; k++) begin
            if (((longint'(a) << (k - 1)) % longint'(b)) == 0) return k + 1;
        end
`endif
        return QW + 1;
    endfunction

    always @(negedge clk) begin
        if (checking && !i_reset) begin
            logic busy;
            logic fin;
            busy = (exp_q.size() > 0) && (exp_q[0].start <= cyc);
            fin  = busy && (cyc == exp_q[0].done);
            chk("done", o_done, fin);
            chk("ready", o_ready, !(busy && cyc < exp_q[0].done));
            if (fin) begin
                chk("quotient", o_quotient, exp_q[0].q);
                chk("sticky", o_sticky, exp_q[0].s);
                chk("divbyzero", o_div_by_zero, exp_q[0].z);
                hold_q = exp_q[0].q;
                hold_s = exp_q[0].s;
                hold_z = exp_q[0].z;
                void'(exp_q.pop_front());
            end else if (!busy) begin
                chk("hold_quotient", o_quotient, hold_q);
                chk("hold_sticky", o_sticky, hold_s);
                chk("hold_dbz", o_div_by_zero, hold_z);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [MW-1:0] a, input logic [MW-1:0] b);
        exp_t e;
        int   guard;
        guard = 0;
        while (exp_q.size() > 0 && cyc < exp_q[exp_q.size()-1].done
               && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) chk("wait_ready_timeout", 1, 0);
        e.start = cyc + 1;
        e.done  = cyc + m_lat(a, b);
        e.q     = m_quot(a, b);
        e.s     = m_sticky(a, b);
        e.z     = (b == 0);
        exp_q.push_back(e);
        i_start    = 1'b1;
        i_dividend = a;
        i_divisor  = b;
        tick();
        i_start    = 1'b0;
        i_dividend = $urandom();
        i_divisor  = $urandom();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            tick();
            guard++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        tick();
    endtask

    function automatic logic [MW-1:0] rnd_mant(input int zero_pct);
        if ($urandom_range(99) < zero_pct) return '0;
        return MW'($urandom()) | 24'h800000;
    endfunction

    initial begin
        logic [MW-1:0] a;
        logic [MW-1:0] b;

        repeat (3) tick();
        i_reset = 1'b0;
        chk("rst_ready", o_ready, 1);
        chk("rst_done", o_done, 0);
        chk("rst_quotient", o_quotient, 0);
        chk("rst_sticky", o_sticky, 0);
        chk("rst_dbz", o_div_by_zero, 0);
        checking = 1'b1;

        chk("model_q_1_1", m_quot(24'h800000, 24'h800000), 26'h2000000);
        chk("model_q_15_1", m_quot(24'hC00000, 24'h800000), 26'h3000000);
        chk("model_q_1_15", m_quot(24'h800000, 24'hC00000), 26'h1555555);
        chk("model_s_1_15", m_sticky(24'h800000, 24'hC00000), 1);
        chk("model_q_div0", m_quot(24'h900000, 24'h000000), 26'h3FFFFFF);
        chk("model_lat_div0", m_lat(24'h900000, 24'h000000), 1);
`ifdef DIV_EARLY_TERM_EN
        chk("model_lat_15_1", m_lat(24'hC00000, 24'h800000), 3);
`else
        chk("model_lat_15_1", m_lat(24'hC00000, 24'h800000), 27);
`endif
        chk("model_lat_1_15", m_lat(24'h800000, 24'hC00000), 27);

        do_op(24'h800000, 24'h800000);
        drain();
        do_op(24'hC00000, 24'h800000);
        drain();
        do_op(24'h800000, 24'hC00000);
        drain();
        do_op(24'h900000, 24'h000000);
        drain();
        do_op(24'h000000, 24'hA00000);
        drain();
        do_op(24'hFFFFFF, 24'h800000);
        drain();
        do_op(24'h800000, 24'hFFFFFF);
        drain();

        do_op(24'hABCDEF, 24'h812345);
        repeat (5) tick();
        i_start    = 1'b1;
        i_dividend = 24'h800000;
        i_divisor  = 24'h000000;
        tick();
        i_start = 1'b0;
        drain();

        do_op(24'h876543, 24'hE00001);
        do_op(24'hC00000, 24'h800000);
        do_op(24'h900000, 24'h000000);
        do_op(24'h812345, 24'h9ABCDE);
        drain();

        do_op(24'hF00000, 24'h900000);
        repeat (10) tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        exp_q.delete();
        hold_q = '0;
        hold_s = 1'b0;
        hold_z = 1'b0;
        chk("midrun_rst_ready", o_ready, 1);
        chk("midrun_rst_quot", o_quotient, 0);
        repeat (30) tick();

        for (int i = 0; i < 150; i++) begin
            a = rnd_mant(10);
            b = rnd_mant(8);
            if ($urandom_range(9) == 0) b = a;
            do_op(a, b);
            if (b != 0 && $urandom_range(3) == 0) begin
                i_start    = 1'b1;
                i_dividend = rnd_mant(0);
                i_divisor  = rnd_mant(0);
                tick();
                i_start = 1'b0;
            end
            if ($urandom_range(1) == 0) begin
                repeat ($urandom_range(30)) tick();
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
